// File: rtl/systolic_job_sched_pkg.sv
// Shared types for the systolic-array job scheduler: array FSM state, scheduler FSM state
// and the job descriptor carried through the FIFO.
package systolic_job_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAITING_MEMORY_A,
        WAITING_MEMORY_B,
        COMPUTE,
        WRITEBACK
    } state_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } sched_state_t;

    typedef struct packed {
        logic [11:0] addr_a;
        logic [11:0] addr_b;
        logic [11:0] addr_c;
        logic [3:0]  n;
        logic [0:0]  src;
        logic [1:0]  tag;
    } job_t;

    function automatic logic n_is_legal(input logic [3:0] n, input int unsigned max_n);
        return (n != 4'd0) && ({28'd0, n} <= max_n);
    endfunction

endpackage

// File: rtl/systolic_job_sched_fifo.sv
// Synchronous FIFO for job descriptors; DEPTH must be a power of two so the pointers
// wrap by natural overflow.
module job_fifo
    import systolic_job_sched_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter type T = job_t
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  T                         push_data,
    input  logic                     pop,
    output T                         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);

    T               mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [AW:0]    count_q, count_d;
    logic           do_push, do_pop;

    assign full     = (count_q == (AW + 1)'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/systolic_job_sched.sv
// Round-robin job scheduler in front of the systolic array: queues descriptors from two
// requesters, issues them one at a time and reports completion, rejection or timeout.
module systolic_job_sched
    import systolic_job_sched_pkg::*;
#(
    parameter int unsigned N       = 4,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [1:0]              req_valid,
    output logic [1:0]              req_ready,
    input  logic [1:0][11:0]        req_addr_a,
    input  logic [1:0][11:0]        req_addr_b,
    input  logic [1:0][11:0]        req_addr_c,
    input  logic [1:0][3:0]         req_n,
    output logic                    arr_new_data,
    output logic [11:0]             arr_addr_A,
    output logic [11:0]             arr_addr_B,
    output logic [11:0]             arr_addr_C,
    output logic [3:0]              arr_n,
    input  state_t                  arr_state,
    output logic                    done_valid,
    output logic                    done_src,
    output logic [1:0]              done_tag,
    output logic                    done_err,
    output logic                    busy,
    output logic [$clog2(DEPTH):0]  q_count
);

    logic                    rr_ptr_q, rr_ptr_d;
    logic [1:0]              tag_q, tag_d;
    logic                    grant, accept;
    job_t                    push_job, head_job;
    logic                    fifo_pop, fifo_full, fifo_empty;
    logic [$clog2(DEPTH):0]  fifo_count;

    sched_state_t            state_q, state_d;
    job_t                    active_q, active_d;
    logic [7:0]              wd_q, wd_d;
    state_t                  arr_state_prev_q;
    logic                    arr_new_data_q, arr_new_data_d;
    logic                    done_valid_q, done_valid_d;
    logic                    done_src_q, done_src_d;
    logic [1:0]              done_tag_q, done_tag_d;
    logic                    done_err_q, done_err_d;
    logic                    wb_fall, wd_expired;

    job_fifo #(
        .DEPTH (DEPTH),
        .T     (job_t)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (accept),
        .push_data (push_job),
        .pop       (fifo_pop),
        .pop_data  (head_job),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Full is taken from the registered count, so a same-cycle pop does not free a slot.
    always_comb begin
        grant     = req_valid[rr_ptr_q] ? rr_ptr_q : ~rr_ptr_q;
        accept    = !rst && (req_valid != 2'b00) && !fifo_full;
        req_ready = 2'b00;
        if (accept) begin
            req_ready[grant] = 1'b1;
        end
        push_job = '{addr_a: req_addr_a[grant], addr_b: req_addr_b[grant],
                     addr_c: req_addr_c[grant], n: req_n[grant], src: grant, tag: tag_q};
        rr_ptr_d = accept ? ~grant : rr_ptr_q;
        tag_d    = accept ? tag_q + 2'd1 : tag_q;
    end

    // wd_q counts WAIT cycles; with the ISSUE and DONE cycles added, the error pulse
    // lands exactly TIMEOUT cycles after the start pulse.
    assign wb_fall    = (arr_state_prev_q == WRITEBACK) && (arr_state != WRITEBACK);
    assign wd_expired = (({1'b0, wd_q} + 9'd2) == 9'(TIMEOUT));

    always_comb begin
        state_d        = state_q;
        active_d       = active_q;
        wd_d           = wd_q;
        fifo_pop       = 1'b0;
        arr_new_data_d = 1'b0;
        done_valid_d   = 1'b0;
        done_src_d     = 1'b0;
        done_tag_d     = 2'b00;
        done_err_d     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    active_d = head_job;
                    if (n_is_legal(head_job.n, N)) begin
                        state_d        = S_ISSUE;
                        arr_new_data_d = 1'b1;
                    end else begin
                        state_d      = S_DONE;
                        done_valid_d = 1'b1;
                        done_src_d   = head_job.src;
                        done_tag_d   = head_job.tag;
                        done_err_d   = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
                wd_d    = 8'd0;
            end
            S_WAIT: begin
                wd_d = wd_q + 8'd1;
                if (wb_fall || wd_expired) begin
                    state_d      = S_DONE;
                    done_valid_d = 1'b1;
                    done_src_d   = active_q.src;
                    done_tag_d   = active_q.tag;
                    done_err_d   = !wb_fall;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q         <= 1'b0;
            tag_q            <= 2'd0;
            state_q          <= S_IDLE;
            active_q         <= '0;
            wd_q             <= 8'd0;
            arr_state_prev_q <= IDLE;
            arr_new_data_q   <= 1'b0;
            done_valid_q     <= 1'b0;
            done_src_q       <= 1'b0;
            done_tag_q       <= 2'd0;
            done_err_q       <= 1'b0;
        end else begin
            rr_ptr_q         <= rr_ptr_d;
            tag_q            <= tag_d;
            state_q          <= state_d;
            active_q         <= active_d;
            wd_q             <= wd_d;
            arr_state_prev_q <= arr_state;
            arr_new_data_q   <= arr_new_data_d;
            done_valid_q     <= done_valid_d;
            done_src_q       <= done_src_d;
            done_tag_q       <= done_tag_d;
            done_err_q       <= done_err_d;
        end
    end

    assign arr_new_data = arr_new_data_q;
    assign arr_addr_A   = active_q.addr_a;
    assign arr_addr_B   = active_q.addr_b;
    assign arr_addr_C   = active_q.addr_c;
    assign arr_n        = active_q.n;
    assign done_valid   = done_valid_q;
    assign done_src     = done_src_q;
    assign done_tag     = done_tag_q;
    assign done_err     = done_err_q;
    assign busy         = !fifo_empty || (state_q != S_IDLE);
    assign q_count      = fifo_count;

endmodule
